alu_writeback: RTL

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/flag_merge.sv | 28 ++
 rtl/alu_writeback.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback slice: flag bit positions, merge classes, FSM states.
// Optional UNDOC_XY_FLAGS_EN keeps the undocumented X/Y flag bits (5 and 3) in F; otherwise they read 0.
package alu_pkg;

   localparam int unsigned FLAG_S = 7;
   localparam int unsigned FLAG_Z = 6;
   localparam int unsigned FLAG_Y = 5;
   localparam int unsigned FLAG_H = 4;
   localparam int unsigned FLAG_X = 3;
   localparam int unsigned FLAG_P = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 0;

   typedef enum logic [1:0] {
      FclassAll    = 2'b00,
      FclassIncDec = 2'b01,
      FclassAdd16  = 2'b10,
      FclassCmp    = 2'b11
   } fclass_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StWrLo = 2'b01,
      StWrHi = 2'b10
   } state_e;

`ifdef UNDOC_XY_FLAGS_EN
   localparam logic [7:0] F_RESET = 8'hFF;
`else
   localparam logic [7:0] F_RESET = 8'hD7;
`endif

   // Every path into F goes through this so X/Y handling lives in one place.
   function automatic logic [7:0] xy_mask(input logic [7:0] f);
      logic [7:0] r;
      r = f;
`ifndef UNDOC_XY_FLAGS_EN
      r[FLAG_Y] = 1'b0;
      r[FLAG_X] = 1'b0;
`endif
      return r;
   endfunction

endpackage

// File: rtl/flag_merge.sv
// Combinational flag merge: combines old F with adder flags according to the instruction class.
// X/Y bits follow UNDOC_XY_FLAGS_EN via alu_pkg::xy_mask.
module flag_merge
   import alu_pkg::*;
(
   input  logic [7:0] f_old,
   input  logic [7:0] flags_in,
   input  logic [1:0] fclass,
   output logic [7:0] f_new
);

   logic [7:0] merged;

   always_comb begin
      merged = flags_in;
      unique case (fclass_e'(fclass))
         FclassIncDec: merged[FLAG_C] = f_old[FLAG_C];
         FclassAdd16: begin
            merged[FLAG_S] = f_old[FLAG_S];
            merged[FLAG_Z] = f_old[FLAG_Z];
            merged[FLAG_P] = f_old[FLAG_P];
         end
         default: ;
      endcase
      f_new = xy_mask(merged);
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: merges flags into F on transfer and writes 8/16-bit results to the byte RF.
// Honours UNDOC_XY_FLAGS_EN (see alu_pkg) for the X/Y flag bits.
module alu_writeback
   import alu_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [15:0]           result,
   input  logic [7:0]            flags_in,
   input  logic                  size,
   input  logic [1:0]            fclass,
   input  logic [REG_ADDR_W-1:0] dest,
   input  logic                  f_load,
   input  logic [7:0]            f_load_data,
   output logic                  wr_en,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [7:0]            wr_data,
   input  logic                  wr_ready,
   output logic [7:0]            f_reg,
   output logic                  done
);

   state_e                  state_q, state_d;
   logic [15:0]             result_q;
   logic                    size_q;
   logic [REG_ADDR_W-1:0]   dest_q;
   logic [7:0]              f_q, f_d, f_merged;
   logic                    done_q, done_d;
   logic                    transfer;
   logic                    is_cmp;

   assign ready_out = (state_q == StIdle);
   assign transfer  = valid_in && ready_out;
   assign is_cmp    = (fclass_e'(fclass) == FclassCmp);
   assign f_reg     = f_q;
   assign done      = done_q;

   flag_merge u_flag_merge (
      .f_old    (f_q),
      .flags_in (flags_in),
      .fclass   (fclass),
      .f_new    (f_merged)
   );

   // A merge on transfer takes priority over a coincident POP AF load.
   always_comb begin
      f_d = f_q;
      if (transfer) begin
         f_d = f_merged;
      end else if (f_load) begin
         f_d = xy_mask(f_load_data);
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      unique case (state_q)
         StIdle: begin
            if (transfer) begin
               if (is_cmp) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StWrLo;
               end
            end
         end
         StWrLo: begin
            wr_en   = 1'b1;
            wr_data = result_q[7:0];
            wr_addr = size_q ? {dest_q[REG_ADDR_W-1:1], 1'b1} : dest_q;
            if (wr_ready) begin
               if (size_q) begin
                  state_d = StWrHi;
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         StWrHi: begin
            wr_en   = 1'b1;
            wr_data = result_q[15:8];
            wr_addr = {dest_q[REG_ADDR_W-1:1], 1'b0};
            if (wr_ready) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         result_q <= '0;
         size_q   <= 1'b0;
         dest_q   <= '0;
         f_q      <= F_RESET;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         done_q  <= done_d;
         if (transfer) begin
            result_q <= result;
            size_q   <= size;
            dest_q   <= dest;
         end
      end
   end

endmodule
